// File: rtl/idex_skid_reg.sv
// idex_skid_reg
// ID/EX pipeline stage register built as a 2-entry valid/ready skid buffer.
// MAIN drives the EX-side outputs. SKID absorbs one extra beat while EX
// back-pressures. A synchronous flush squashes everything held plus the
// same-cycle input beat. Two saturating counters track stall and flush cycles.
//
// state | meaning
// EMPTY | no valid beat held, outputs are a bubble
// ONE   | MAIN holds a valid beat, SKID unused
// TWO   | MAIN and SKID both hold valid beats, upstream is held off
//
// Ports
//   clk, reset                 clock, async active-low reset
//   in_valid / in_ready        upstream handshake (in_ready is a flop)
//   ctrl_in ... rd_in          incoming decode payload
//   out_valid / out_ready      EX-side handshake
//   ctrl_out ... rd_out        MAIN payload (ctrl gated by out_valid)
//   flush                      squash held and incoming beats
//   cnt_clr                    clear both performance counters
//   stall_cnt, flush_cnt       saturating performance counters
module idex_skid_reg #(
    parameter int CTRL_W = 9,
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] pc4_in,
    input  logic [DATA_W-1:0] rd1_in,
    input  logic [DATA_W-1:0] rd2_in,
    input  logic [IMM_W-1:0]  imm_in,
    input  logic [REG_W-1:0]  rs_in,
    input  logic [REG_W-1:0]  rt_in,
    input  logic [REG_W-1:0]  rd_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] pc4_out,
    output logic [DATA_W-1:0] rd1_out,
    output logic [DATA_W-1:0] rd2_out,
    output logic [IMM_W-1:0]  imm_out,
    output logic [REG_W-1:0]  rs_out,
    output logic [REG_W-1:0]  rt_out,
    output logic [REG_W-1:0]  rd_out,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int PW = CTRL_W + 3*DATA_W + IMM_W + 3*REG_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [PW-1:0]     in_beat;
    logic [PW-1:0]     main_q;
    logic [PW-1:0]     skid_q;
    logic [CTRL_W-1:0] main_ctrl;

    logic accept;
    logic fire;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;
    logic stall_inc;
    logic flush_inc;

    assign in_beat = {ctrl_in, pc4_in, rd1_in, rd2_in, imm_in, rs_in, rt_in, rd_in};
    assign {main_ctrl, pc4_out, rd1_out, rd2_out, imm_out, rs_out, rt_out, rd_out} = main_q;

    assign out_valid = (state != EMPTY);
    assign ctrl_out  = main_ctrl & {CTRL_W{out_valid}};

    assign accept = in_valid & in_ready;
    assign fire   = out_valid & out_ready;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            // Squash wins over everything; payload is left as-is since
            // ctrl_out is already gated by out_valid.
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        load_main_in = 1'b1;
                        state_nxt    = ONE;
                    end
                end
                ONE: begin
                    if (accept && fire) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        state_nxt = TWO;
                    end else if (fire) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only the drain path exists.
                    if (fire) begin
                        load_main_skid = 1'b1;
                        state_nxt      = ONE;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    assign stall_inc = out_valid & ~out_ready & ~flush;
    assign flush_inc = flush & (out_valid | accept);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= EMPTY;
            in_ready <= 1'b0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != TWO);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= in_beat;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_beat;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_inc && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_idex_skid_reg.sv
module tb_idex_skid_reg;

    localparam int CTRL_W = 9;
    localparam int DATA_W = 32;
    localparam int IMM_W  = 16;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = 15;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] pc4;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [IMM_W-1:0]  imm;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
    } beat_t;

    typedef struct {
        logic        iv;
        logic        ordy;
        logic        fl;
        logic        clr;
        logic [31:0] pc4;
        logic        ev;
        logic        er;
        logic [31:0] epc4;
        int          estall;
        int          eflush;
    } vec_t;

    logic clk;
    logic reset;
    logic in_valid, in_ready, out_valid, out_ready, flush, cnt_clr;
    beat_t drv;
    logic [CTRL_W-1:0] ctrl_out;
    logic [DATA_W-1:0] pc4_out, rd1_out, rd2_out;
    logic [IMM_W-1:0]  imm_out;
    logic [REG_W-1:0]  rs_out, rt_out, rd_out;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    idex_skid_reg #(
        .CTRL_W(CTRL_W), .DATA_W(DATA_W), .IMM_W(IMM_W), .REG_W(REG_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .ctrl_in(drv.ctrl), .pc4_in(drv.pc4), .rd1_in(drv.rd1), .rd2_in(drv.rd2),
        .imm_in(drv.imm), .rs_in(drv.rs), .rt_in(drv.rt), .rd_in(drv.rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .ctrl_out(ctrl_out), .pc4_out(pc4_out), .rd1_out(rd1_out), .rd2_out(rd2_out),
        .imm_out(imm_out), .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
        .flush(flush), .cnt_clr(cnt_clr),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_beat(input logic [31:0] pc4);
        drv.ctrl = 9'h1A5;
        drv.pc4  = pc4;
        drv.rd1  = pc4 ^ 32'hA5A5_0000;
        drv.rd2  = pc4 ^ 32'h0000_5A5A;
        drv.imm  = pc4[15:0];
        drv.rs   = pc4[6:2];
        drv.rt   = 5'd7;
        drv.rd   = 5'd9;
    endtask

    vec_t tbl[17];

    // Reference model state: a FIFO of held beats plus the last beat
    // shown in MAIN, which stays on the data outputs after it leaves.
    beat_t q[$];
    beat_t shadow;
    logic  m_rdy;
    int    m_stall, m_flush;

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h04, 1'b1, 1'b1, 32'h04, 0, 0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h08, 1'b1, 1'b1, 32'h08, 0, 0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0C, 1'b1, 1'b1, 32'h0C, 0, 0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 1'b1, 32'h10, 0, 0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 32'h10, 0, 0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h04, 1'b1, 1'b1, 32'h04, 0, 0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h08, 1'b1, 1'b0, 32'h04, 1, 0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0C, 1'b1, 1'b0, 32'h04, 2, 0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0C, 1'b1, 1'b0, 32'h04, 3, 0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0C, 1'b1, 1'b1, 32'h08, 3, 0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0C, 1'b1, 1'b1, 32'h0C, 3, 0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 32'h0C, 3, 0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 1'b1, 1'b1, 32'h40, 3, 0};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h44, 1'b1, 1'b0, 32'h40, 4, 0};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h48, 1'b0, 1'b1, 32'h40, 4, 1};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h20, 1'b1, 1'b1, 32'h20, 4, 1};
        tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 32'h20, 4, 1};

        // Reset with in_valid held high.
        reset = 1'b0; in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
        set_beat(32'h4);
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ctrl_out", ctrl_out, 0);
        chk("rst_pc4_out", pc4_out, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
        reset = 1'b1;
        #1;
        chk("rel_in_ready_first", in_ready, 0);
        @(posedge clk); #1;
        chk("rel_in_ready_edge1", in_ready, 1);
        chk("rel_out_valid_edge1", out_valid, 0);
        @(posedge clk); #1;
        chk("rel_out_valid_edge2", out_valid, 1);
        chk("rel_pc4_edge2", pc4_out, 32'h4);
        chk("rel_ctrl_edge2", ctrl_out, 9'h1A5);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("drain_out_valid", out_valid, 0);
        chk("drain_in_ready", in_ready, 1);

        // Table-driven streaming, stall and flush sequences.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            in_valid = tbl[i].iv; out_ready = tbl[i].ordy;
            flush = tbl[i].fl; cnt_clr = tbl[i].clr;
            set_beat(tbl[i].pc4);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].ev);
            chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].er);
            chk($sformatf("tbl%0d_pc4_out", i), pc4_out, tbl[i].epc4);
            chk($sformatf("tbl%0d_ctrl_out", i), ctrl_out, tbl[i].ev ? 9'h1A5 : 9'h000);
            chk($sformatf("tbl%0d_stall_cnt", i), stall_cnt, tbl[i].estall);
            chk($sformatf("tbl%0d_flush_cnt", i), flush_cnt, tbl[i].eflush);
        end

        // Stall counter saturation, then clear against a same-cycle stall.
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
        set_beat(32'h100);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("sat_stall_cnt", stall_cnt, CNT_MAX);
        chk("sat_pc4_hold", pc4_out, 32'h100);
        chk("sat_out_valid", out_valid, 1);
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        chk("clr_stall_cnt", stall_cnt, 0);
        chk("clr_flush_cnt", flush_cnt, 0);
        @(negedge clk);
        cnt_clr = 1'b0;
        @(posedge clk); #1;
        chk("post_clr_stall_cnt", stall_cnt, 1);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);

        // Asynchronous reset between edges while holding two beats.
        in_valid = 1'b1; out_ready = 1'b0;
        set_beat(32'h200);
        @(negedge clk);
        set_beat(32'h204);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("areset_out_valid", out_valid, 0);
        chk("areset_ctrl_out", ctrl_out, 0);
        chk("areset_in_ready", in_ready, 0);
        chk("areset_stall_cnt", stall_cnt, 0);
        chk("areset_flush_cnt", flush_cnt, 0);
        chk("areset_pc4_out", pc4_out, 0);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("areset_no_stale%0d", i), out_valid, 0);
        end

        // Randomized traffic against the queue model.
        q.delete();
        shadow  = '0;
        m_rdy   = 1'b1;
        m_stall = 0;
        m_flush = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic acc, fir;
            @(negedge clk);
            chk("rnd_out_valid", out_valid, q.size() != 0);
            chk("rnd_in_ready", in_ready, m_rdy);
            chk("rnd_ctrl_out", ctrl_out, (q.size() != 0) ? q[0].ctrl : '0);
            chk("rnd_pay_a", {imm_out, rs_out, rt_out, rd_out, pc4_out},
                {shadow.imm, shadow.rs, shadow.rt, shadow.rd, shadow.pc4});
            chk("rnd_pay_b", {rd1_out, rd2_out}, {shadow.rd1, shadow.rd2});
            chk("rnd_stall_cnt", stall_cnt, m_stall);
            chk("rnd_flush_cnt", flush_cnt, m_flush);

            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            cnt_clr   = ($urandom_range(0, 31) == 0);
            drv.ctrl  = CTRL_W'($urandom);
            drv.pc4   = $urandom;
            drv.rd1   = $urandom;
            drv.rd2   = $urandom;
            drv.imm   = IMM_W'($urandom);
            drv.rs    = REG_W'($urandom);
            drv.rt    = REG_W'($urandom);
            drv.rd    = REG_W'($urandom);

            acc = in_valid & m_rdy;
            fir = (q.size() != 0) & out_ready;
            @(posedge clk);
            if (cnt_clr) begin
                m_stall = 0;
                m_flush = 0;
            end else begin
                if ((q.size() != 0) && !out_ready && !flush && m_stall < CNT_MAX) m_stall++;
                if (flush && ((q.size() != 0) || acc) && m_flush < CNT_MAX) m_flush++;
            end
            if (flush) begin
                q.delete();
                m_rdy = 1'b1;
            end else begin
                if (fir) q.delete(0);
                if (acc) q.push_back(drv);
                m_rdy = (q.size() < 2);
            end
            if (q.size() != 0) shadow = q[0];
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
